cpa_nibble_seq: RTL and testbench
=================================

// Module: cpa_nibble_seq
// PURPOSE
//   Multi-cycle sequencer that reuses a single 4-bit carry-propagate slice
//   to add WIDTH-bit operands, one nibble per clock, LSB nibble first.
//   Saves area next to the fully unrolled 16-bit CPA, at the cost of latency.
//   Sits between an operand producer and a result consumer, using valid/ready
//   handshakes on both sides. One operation is in flight at a time.
// PARAMETERS
//   WIDTH  16  Operand and sum width. Must be a multiple of 4 and >= 4;
//              any other value is an elaboration error. NIB = WIDTH/4.
// PORTS
//   clk        in   1      Clock. All state updates on the rising edge.
//   rst        in   1      Reset. Asynchronous, active-high.
//   in_valid   in   1      Operand set valid.
//   in_ready   out  1      Sequencer can accept operands (IDLE only).
//   a          in   WIDTH  Operand a.
//   b          in   WIDTH  Operand b.
//   c_in       in   1      Carry into bit 0.
//   out_valid  out  1      Result valid (DONE state).
//   out_ready  in   1      Consumer accepts the result.
//   s          out  WIDTH  Sum, registered.
//   c_out      out  1      Carry out of bit WIDTH-1, registered.
//   busy       out  1      High in RUN or DONE.
//   sub        in   1      [CPA_SUB_EN only] 1 = subtract (a - b).
//   ovf        out  1      [CPA_SUB_EN only] Signed overflow of the result.
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, cnt=0, carry=0,
//     s=0, c_out=0, out_valid=0, busy=0, ovf=0; in_ready=1 once in IDLE.
//     An in-flight operation is discarded; nothing is emitted for it.
//   States: IDLE, RUN, DONE.
//   IDLE: in_ready=1. When in_valid is high, capture a_r=a, b_r=b,
//     carry=c_in, cnt=0, and move to RUN.
//   RUN: slice adds a_r[3:0] + b_r[3:0] + carry.
//     - The sum nibble shifts into s_r from the top: s_r = {nib, s_r[W-1:4]}.
//     - a_r and b_r shift right by 4; carry takes the slice carry-out.
//     - cnt increments. When cnt == NIB-1, move to DONE.
//   DONE: out_valid=1; s and c_out (= carry) are held stable.
//     When out_ready is high, move to IDLE.
//   Latency: out_valid rises exactly NIB cycles after the accept edge.
//     Minimum issue interval is NIB+2 cycles.
//   in_ready is 0 in RUN and DONE. in_valid in those states is ignored,
//     and the producer must hold its data.
//   In DONE, an out handshake in the same cycle as in_valid does not accept
//     the new operands; acceptance happens on the following IDLE cycle.
//   s and c_out update only on the RUN->DONE transition. Outside DONE they
//     hold the last result; they are not valid unless out_valid is high.
//   Arithmetic is modulo 2^WIDTH. c_out is the true carry out of the MSB.
// CONFIGURATION
//   CPA_SUB_EN defined:
//     - The sub and ovf ports exist.
//     - At capture with sub=1: b_r = ~b and carry = 1; c_in is ignored.
//     - c_out is the no-borrow flag (1 when a >= b, unsigned).
//     - ovf = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]), registered with s.
//   CPA_SUB_EN undefined:
//     - The sub and ovf ports are absent; the block is add-only.
// STRUCTURE
//   Package cpa_pkg: NIB_W=4 localparam; state enum {IDLE, RUN, DONE}.
//   Sub-module cpa4_slice: a combinational 4-bit ripple adder,
//     (a[3:0], b[3:0], c_in) -> (s[3:0], c_out). The sequencer holds
//     registers and FSM only.
// TESTING
//   1. 16'hFFFF + 16'h0001, c_in=0 -> s=16'h0000, c_out=1; out_valid 4 cycles after accept.
//   2. 16'h1234 + 16'h4321, c_in=1 -> s=16'h5556, c_out=0.
//   3. out_ready held 0 for 10 cycles in DONE -> s, c_out, out_valid stable; in_ready=0.
//   4. rst pulsed mid-RUN (cnt=2) -> out_valid=0, in_ready=1; next op 16'h0001+16'h0001 -> 16'h0002.
//   5. WIDTH=8: 8'hFF + 8'h01 -> s=8'h00, c_out=1, out_valid 2 cycles after accept.
//   6. CPA_SUB_EN: 16'h0005-16'h0007 -> 16'hFFFE, c_out=0, ovf=0;
//      16'h8000-16'h0001 -> 16'h7FFF, ovf=1.

Source files
------------

// File: rtl/cpa_nibble_seq_pkg.sv
// Shared constants and FSM state type for the nibble-serial carry-propagate adder.
// Imported by cpa4_slice and cpa_nibble_seq.
package cpa_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble counter needs at least one bit even for a single-nibble datapath.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cpa_nibble_seq_if.sv
// Operand/result handshake bundle for cpa_nibble_seq.
// CPA_SUB_EN adds the sub request and ovf result signals.
interface cpa_nibble_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             busy;
`ifdef CPA_SUB_EN
  logic             sub;
  logic             ovf;
`endif

`ifdef CPA_SUB_EN
  modport master (
    output in_valid, a, b, c_in, out_ready, sub,
    input  in_ready, out_valid, s, c_out, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready, sub,
    output in_ready, out_valid, s, c_out, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, s, c_out, busy
  );
`endif

endinterface

// File: rtl/cpa_nibble_seq_slice.sv
// Combinational 4-bit ripple-carry adder slice reused once per clock by the sequencer.
module cpa4_slice
  import cpa_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_c,
  output logic [NIB_W-1:0] o_s,
  output logic             o_c
);

  logic w_rc;

  always_comb begin
    w_rc = i_c;
    o_s  = '0;
    for (int i = 0; i < NIB_W; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_rc;
      w_rc   = (i_a[i] & i_b[i]) | (w_rc & (i_a[i] ^ i_b[i]));
    end
    o_c = w_rc;
  end

endmodule

// File: rtl/cpa_nibble_seq.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice, one nibble per clock, LSB nibble first.
// Define CPA_SUB_EN to add subtraction (sub) and signed overflow (ovf).
module cpa_nibble_seq
  import cpa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  cpa_nibble_seq_if.slave io_bus
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("cpa_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_c_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_in_ready;

  logic [NIB_W-1:0] w_nib;
  logic             w_nib_c;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_c_cap;

  cpa4_slice u_slice (
    .i_a (r_a[NIB_W-1:0]),
    .i_b (r_b[NIB_W-1:0]),
    .i_c (r_carry),
    .o_s (w_nib),
    .o_c (w_nib_c)
  );

  // New sum nibble enters from the top so the LSB nibble ends up at the bottom.
  assign w_acc_next = WIDTH'({w_nib, r_acc} >> NIB_W);

`ifdef CPA_SUB_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // a - b == a + ~b + 1; c_in has no meaning for a subtract.
  assign w_b_cap = io_bus.sub ? ~io_bus.b : io_bus.b;
  assign w_c_cap = io_bus.sub | io_bus.c_in;
  assign io_bus.ovf = r_ovf;
`else
  assign w_b_cap = io_bus.b;
  assign w_c_cap = io_bus.c_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_s         <= '0;
      r_carry     <= 1'b0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef CPA_SUB_EN
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_a        <= io_bus.a;
            r_b        <= w_b_cap;
            r_carry    <= w_c_cap;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
`ifdef CPA_SUB_EN
            r_a_msb    <= io_bus.a[WIDTH-1];
            r_b_msb    <= w_b_cap[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_a     <= r_a >> NIB_W;
          r_b     <= r_b >> NIB_W;
          r_carry <= w_nib_c;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_s         <= w_acc_next;
            r_c_out     <= w_nib_c;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef CPA_SUB_EN
            r_ovf <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
`endif
          end
        end
        DONE: begin
          // Returning to IDLE only; new operands are taken on the next cycle.
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.s         = r_s;
  assign io_bus.c_out     = r_c_out;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_cpa_nibble_seq.sv
// Self-checking bench for cpa_nibble_seq: 16-bit and 8-bit instances, directed and random ops.
// Honours CPA_SUB_EN when defined for both bench and design.
module tb_cpa_nibble_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cpa_nibble_seq_if #(.WIDTH(16)) bus16 ();
  cpa_nibble_seq_if #(.WIDTH(8))  bus8 ();

  cpa_nibble_seq #(.WIDTH(16)) u_dut16 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus16)
  );

  cpa_nibble_seq #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus8)
  );

  // Drive one operand set, return at the negedge where out_valid is seen (or timeout).
  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, output int lat);
    @(negedge clk);
    bus16.a        = a;
    bus16.b        = b;
    bus16.c_in     = ci;
    bus16.in_valid = 1'b1;
`ifdef CPA_SUB_EN
    bus16.sub      = sb;
`endif
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_out16(output int lat);
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish16;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int lat);
    @(negedge clk);
    bus8.a        = a;
    bus8.b        = b;
    bus8.c_in     = ci;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish8;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy, bus16.c_out, bus16.s} !== {4'b1000, 16'h0})
    begin
      n_err++;
      $display("FAIL reset16 got rdy/vld/busy/co/s=%b%b%b%b/%h want 1000/0000",
               bus16.in_ready, bus16.out_valid, bus16.busy, bus16.c_out, bus16.s);
    end
    n_cmp++;
    if ({bus8.in_ready, bus8.out_valid, bus8.busy, bus8.c_out, bus8.s} !== {4'b1000, 8'h0}) begin
      n_err++;
      $display("FAIL reset8 got rdy/vld/busy/co/s=%b%b%b%b/%h want 1000/00",
               bus8.in_ready, bus8.out_valid, bus8.busy, bus8.c_out, bus8.s);
    end
`ifdef CPA_SUB_EN
    n_cmp++;
    if (bus16.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf got=%b want=0", bus16.ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int lat;
    do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL dir1_latency got=%0d want=4", lat);
    end
    n_cmp++;
    if ({bus16.c_out, bus16.s, bus16.busy} !== {1'b1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL dir1_sum got co/s/busy=%b/%h/%b want 1/0000/1",
               bus16.c_out, bus16.s, bus16.busy);
    end
    finish16();
    n_cmp++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy} !== 3'b100) begin
      n_err++;
      $display("FAIL dir1_idle got rdy/vld/busy=%b%b%b want 100",
               bus16.in_ready, bus16.out_valid, bus16.busy);
    end
    do_op16(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    n_cmp++;
    if ({bus16.c_out, bus16.s} !== {1'b0, 16'h5556} || lat !== 4) begin
      n_err++;
      $display("FAIL dir2_sum got co/s/lat=%b/%h/%0d want 0/5556/4", bus16.c_out, bus16.s, lat);
    end
    finish16();
  endtask

  // Hold DONE with a pending in_valid; the out handshake must not also accept.
  task automatic test_hold_back_to_back;
    int lat;
    do_op16(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus16.a        = 16'h0003;
      bus16.b        = 16'h0004;
      bus16.c_in     = 1'b0;
      bus16.in_valid = 1'b1;
`ifdef CPA_SUB_EN
      bus16.sub      = 1'b0;
`endif
      n_cmp++;
      if ({bus16.out_valid, bus16.in_ready, bus16.c_out, bus16.s} !== {3'b100, 16'hFFFF}) begin
        n_err++;
        $display("FAIL hold_cyc%0d got vld/rdy/co/s=%b%b%b/%h want 100/ffff", i,
                 bus16.out_valid, bus16.in_ready, bus16.c_out, bus16.s);
      end
    end
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    n_cmp++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy} !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_idle got rdy/vld/busy=%b%b%b want 100",
               bus16.in_ready, bus16.out_valid, bus16.busy);
    end
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    wait_out16(lat);
    n_cmp++;
    if ({bus16.c_out, bus16.s} !== {1'b0, 16'h0007} || lat !== 4) begin
      n_err++;
      $display("FAIL b2b_sum got co/s/lat=%b/%h/%0d want 0/0007/4", bus16.c_out, bus16.s, lat);
    end
    finish16();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    @(negedge clk);
    bus16.a        = 16'h7777;
    bus16.b        = 16'h1111;
    bus16.c_in     = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus16.out_valid, bus16.in_ready, bus16.busy, bus16.c_out, bus16.s} !== {4'b0100, 16'h0})
    begin
      n_err++;
      $display("FAIL midrun_rst got vld/rdy/busy/co/s=%b%b%b%b/%h want 0100/0000",
               bus16.out_valid, bus16.in_ready, bus16.busy, bus16.c_out, bus16.s);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op16(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    n_cmp++;
    if ({bus16.c_out, bus16.s} !== {1'b0, 16'h0002} || lat !== 4) begin
      n_err++;
      $display("FAIL midrun_next got co/s/lat=%b/%h/%0d want 0/0002/4", bus16.c_out, bus16.s, lat);
    end
    finish16();
  endtask

`ifdef CPA_SUB_EN
  task automatic test_sub;
    int lat;
    do_op16(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    n_cmp++;
    if ({bus16.c_out, bus16.ovf, bus16.s} !== {2'b00, 16'hFFFE} || lat !== 4) begin
      n_err++;
      $display("FAIL sub1 got co/ovf/s/lat=%b/%b/%h/%0d want 0/0/fffe/4",
               bus16.c_out, bus16.ovf, bus16.s, lat);
    end
    finish16();
    do_op16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    n_cmp++;
    if ({bus16.c_out, bus16.ovf, bus16.s} !== {2'b11, 16'h7FFF}) begin
      n_err++;
      $display("FAIL sub2 got co/ovf/s=%b/%b/%h want 1/1/7fff", bus16.c_out, bus16.ovf, bus16.s);
    end
    finish16();
  endtask
`endif

  // Reference: plain integer arithmetic on the operands.
  task automatic test_random16;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_s;
      logic        ci;
      logic        sb;
      logic        exp_c;
      logic        exp_ovf;
      int          ia;
      int          ib;
      int          sd;
      int          lat;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      sb = 1'b0;
`ifdef CPA_SUB_EN
      sb = 1'($urandom_range(0, 1));
`endif
      ia = $signed(a);
      ib = $signed(b);
      if (sb) begin
        exp_s = a - b;
        exp_c = (a >= b);
        sd    = ia - ib;
      end else begin
        {exp_c, exp_s} = {1'b0, a} + {1'b0, b} + 17'(ci);
        sd    = ia + ib + int'(ci);
      end
      exp_ovf = (sd > 32767) || (sd < -32768);
      do_op16(a, b, ci, sb, lat);
      n_cmp++;
      if ({bus16.c_out, bus16.s} !== {exp_c, exp_s} || lat !== 4) begin
        n_err++;
        $display("FAIL rnd16_%0d a=%h b=%h ci=%b sub=%b got co/s/lat=%b/%h/%0d want %b/%h/4",
                 i, a, b, ci, sb, bus16.c_out, bus16.s, lat, exp_c, exp_s);
      end
`ifdef CPA_SUB_EN
      n_cmp++;
      if (bus16.ovf !== exp_ovf) begin
        n_err++;
        $display("FAIL rnd16_ovf_%0d a=%h b=%h sub=%b got=%b want=%b",
                 i, a, b, sb, bus16.ovf, exp_ovf);
      end
`else
      if (exp_ovf === 1'bx) $display("note: unexpected x in overflow model");
`endif
      finish16();
    end
  endtask

  task automatic test_width8;
    int lat;
    do_op8(8'hFF, 8'h01, 1'b0, lat);
    n_cmp++;
    if ({bus8.c_out, bus8.s} !== {1'b1, 8'h00} || lat !== 2) begin
      n_err++;
      $display("FAIL w8_dir got co/s/lat=%b/%h/%0d want 1/00/2", bus8.c_out, bus8.s, lat);
    end
    finish8();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_s;
      logic       ci;
      logic       exp_c;
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom_range(0, 1));
      {exp_c, exp_s} = {1'b0, a} + {1'b0, b} + 9'(ci);
      do_op8(a, b, ci, lat);
      n_cmp++;
      if ({bus8.c_out, bus8.s} !== {exp_c, exp_s} || lat !== 2) begin
        n_err++;
        $display("FAIL w8_rnd_%0d a=%h b=%h ci=%b got co/s/lat=%b/%h/%0d want %b/%h/2",
                 i, a, b, ci, bus8.c_out, bus8.s, lat, exp_c, exp_s);
      end
      finish8();
    end
  endtask

  initial begin
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.c_in      = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.out_ready  = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.c_in       = 1'b0;
`ifdef CPA_SUB_EN
    bus16.sub       = 1'b0;
    bus8.sub        = 1'b0;
`endif
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_reset_mid_run();
`ifdef CPA_SUB_EN
    test_sub();
`endif
    test_random16();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
